// File: rtl/img_ctrl_pkg.sv
// Shared types and geometry for the SRAM-backed disk image controller.
// One 512-byte sector per LBA; the image occupies a 19-bit byte space.
package img_ctrl_pkg;

  localparam int SECTOR_BITS  = 9;
  localparam int SECTOR_BYTES = 1 << SECTOR_BITS;
  localparam int SRAM_AW      = 19;
  localparam int LBA_BITS     = SRAM_AW - SECTOR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sram_image_controller.sv
// Serves u765 sd_* sector requests from a pre-loaded, read-only image SRAM.
// Reads stream one byte per two clocks; writes are acknowledged and dropped.
module sram_image_controller
  import img_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [31:0]            sd_lba,
  input  logic [1:0]             sd_rd,
  input  logic [1:0]             sd_wr,
  output logic                   sd_ack,
  output logic [SECTOR_BITS-1:0] sd_buff_addr,
  output logic [7:0]             sd_buff_dout,
  input  logic [7:0]             sd_buff_din,
  output logic                   sd_buff_wr,
  output logic [SRAM_AW-1:0]     sram_addr_o,
  input  logic [7:0]             sram_data_i
);

  state_t                 state, next_state;
  logic [LBA_BITS-1:0]    lba;
  logic [SECTOR_BITS-1:0] index;
  logic                   req_rd, req_wr, last_byte;

  // Write data and the upper LBA bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{sd_buff_din, sd_lba[31:LBA_BITS]};

  assign req_rd    = |sd_rd;
  assign req_wr    = |sd_wr;
  assign last_byte = (index == SECTOR_BITS'(SECTOR_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= next_state;
  end

  // NOTE: next_state gets its default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_rd)      next_state = ST_RD_ADDR;
        else if (req_wr) next_state = ST_WR;
      end
      ST_RD_ADDR: next_state = ST_RD_DATA;
      ST_RD_DATA: next_state = last_byte ? ST_DONE : ST_RD_ADDR;
      ST_WR:      if (last_byte) next_state = ST_DONE;
      ST_DONE:    if (!req_rd && !req_wr) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // SRAM address is presented during RD_ADDR; its data is registered in RD_DATA.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lba          <= '0;
      index        <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      sram_addr_o  <= '0;
    end else begin
      sd_buff_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_rd || req_wr) begin
            lba          <= sd_lba[LBA_BITS-1:0];
            index        <= '0;
            sd_ack       <= 1'b1;
            sd_buff_addr <= '0;
            if (req_rd) sram_addr_o <= {sd_lba[LBA_BITS-1:0], {SECTOR_BITS{1'b0}}};
          end
        end
        ST_RD_DATA: begin
          sd_buff_dout <= sram_data_i;
          sd_buff_addr <= index;
          sd_buff_wr   <= 1'b1;
          if (!last_byte) begin
            index       <= index + 1'b1;
            sram_addr_o <= {lba, index + 1'b1};
          end
        end
        ST_WR: begin
          if (last_byte) begin
            sd_ack <= 1'b0;
          end else begin
            index        <= index + 1'b1;
            sd_buff_addr <= index + 1'b1;
          end
        end
        // Ack is held through the final strobe of a read, then released.
        ST_DONE: sd_ack <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_image_controller.sv
// Self-checking bench: synchronous-read SRAM image plus an address-mapping model
// (byte = image[(lba mod 1024)*512 + index]) checked against captured strobes.
module tb_sram_image_controller;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic [18:0] sram_addr_o;
  logic [7:0]  sram_data_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] mem [0:524287];

  // Capture results of the most recent transaction.
  int          n_strobes, ack_rises, ack_cycles, first_ack;
  int          order_err, data_err, sweep_err;
  logic [18:0] addr_min, addr_max, addr_at_start;
  logic        ack_end;
  logic [7:0]  cap [0:511];

  sram_image_controller dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .sram_addr_o  (sram_addr_o),
    .sram_data_i  (sram_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) sram_data_i <= mem[sram_addr_o];

  function automatic int ref_index(input logic [31:0] lba, input int idx);
    return int'(lba % 32'd1024) * 512 + idx;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  // Drive one request, run a fixed number of cycles, and record what the DUT did.
  task automatic run_txn(input logic [31:0] lba, input logic [1:0] rd, input logic [1:0] wr,
                         input int hold, input int cycles);
    logic prev_ack;
    n_strobes = 0; ack_rises = 0; ack_cycles = 0; first_ack = -1;
    order_err = 0; data_err = 0; sweep_err = 0;
    addr_min = '1; addr_max = '0; addr_at_start = sram_addr_o;
    for (int i = 0; i < 512; i++) cap[i] = 8'hxx;
    prev_ack = sd_ack;
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk_i);
      if (n == hold) begin sd_rd = 2'b00; sd_wr = 2'b00; end
      if (n == 2) sd_lba = $urandom;
      sd_buff_din = 8'($urandom);
      if (sd_ack && !prev_ack) ack_rises++;
      if (sd_ack && first_ack < 0) first_ack = n;
      if (sd_ack) begin
        if (sd_buff_addr !== 9'(ack_cycles)) sweep_err++;
        ack_cycles++;
        if (sram_addr_o < addr_min) addr_min = sram_addr_o;
        if (sram_addr_o > addr_max) addr_max = sram_addr_o;
      end
      if (sd_buff_wr) begin
        if (sd_buff_addr !== 9'(n_strobes)) order_err++;
        if (sd_buff_dout !== mem[ref_index(lba, int'(sd_buff_addr))]) data_err++;
        cap[sd_buff_addr] = sd_buff_dout;
        n_strobes++;
      end
      prev_ack = sd_ack;
    end
    ack_end = sd_ack;
  endtask

  task automatic check_read(input string name, input logic [31:0] lba);
    chk({name, " strobes"}, n_strobes, 512);
    chk({name, " order"}, order_err, 0);
    chk({name, " data"}, data_err, 0);
    chk({name, " ack_rises"}, ack_rises, 1);
    chk({name, " ack_latency_ok"}, (first_ack >= 1 && first_ack <= 2), 1);
    chk({name, " ack_end"}, ack_end, 0);
    chk({name, " addr_min"}, addr_min, ref_index(lba, 0));
    chk({name, " addr_max"}, addr_max, ref_index(lba, 511));
  endtask

  task automatic test_reset();
    reset_i = 1'b1; sd_rd = 2'b01; sd_wr = 2'b10; sd_lba = 32'd5;
    repeat (5) @(negedge clk_i);
    chk("reset sd_ack", sd_ack, 0);
    chk("reset sd_buff_wr", sd_buff_wr, 0);
    chk("reset sd_buff_addr", sd_buff_addr, 0);
    chk("reset sd_buff_dout", sd_buff_dout, 0);
    chk("reset sram_addr", sram_addr_o, 0);
    sd_rd = 2'b00; sd_wr = 2'b00;
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_header_read();
    run_txn(32'd0, 2'b01, 2'b00, 1, 1100);
    check_read("hdr", 32'd0);
    chk("hdr byte 000", cap[9'h000], 8'h4D);
    chk("hdr byte 001", cap[9'h001], 8'h56);
    chk("hdr byte 030", cap[9'h030], 8'h28);
    chk("hdr byte 032", cap[9'h032], 8'h00);
    chk("hdr byte 033", cap[9'h033], 8'h13);
    chk("hdr byte 100", cap[9'h100], 8'h54);
    chk("hdr byte 115", cap[9'h115], 8'h09);
  endtask

  task automatic test_lba_wrap();
    run_txn(32'd3, 2'b10, 2'b00, 1, 1100);
    check_read("lba3", 32'd3);
    run_txn(32'd1027, 2'b01, 2'b00, 1, 1100);
    check_read("lba1027", 32'd1027);
    chk("wrap addr_min", addr_min, 19'h600);
  endtask

  task automatic test_random_reads();
    logic [31:0] lba;
    for (int k = 0; k < 3; k++) begin
      lba = $urandom;
      run_txn(lba, 2'($urandom_range(1, 3)), 2'b00, 1, 1100);
      check_read($sformatf("rand%0d", k), lba);
    end
  endtask

  task automatic test_held_request();
    run_txn(32'd7, 2'b01, 2'b00, 2000, 2010);
    check_read("held", 32'd7);
    run_txn(32'd8, 2'b01, 2'b00, 1, 1100);
    check_read("reassert", 32'd8);
  endtask

  task automatic test_write();
    run_txn(32'd12, 2'b00, 2'b10, 1, 600);
    chk("wr ack_cycles", ack_cycles, 512);
    chk("wr sweep", sweep_err, 0);
    chk("wr strobes", n_strobes, 0);
    chk("wr ack_rises", ack_rises, 1);
    chk("wr sram_addr held lo", addr_min, addr_at_start);
    chk("wr sram_addr held hi", addr_max, addr_at_start);
    run_txn(32'd21, 2'b01, 2'b01, 1, 1100);
    check_read("rdwr_prio", 32'd21);
  endtask

  task automatic test_reset_mid_read();
    bit found = 0;
    sd_lba = 32'd40; sd_rd = 2'b01; sd_wr = 2'b00;
    @(negedge clk_i);
    sd_rd = 2'b00;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk_i);
      if (sd_buff_wr && sd_buff_addr == 9'd100) found = 1;
    end
    chk("midrst reached byte 100", found, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("midrst sd_ack", sd_ack, 0);
    chk("midrst sd_buff_wr", sd_buff_wr, 0);
    chk("midrst sram_addr", sram_addr_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    run_txn(32'd41, 2'b01, 2'b00, 1, 1100);
    check_read("post_rst", 32'd41);
  endtask

  initial begin
    string s;
    reset_i = 1'b1; sd_lba = '0; sd_rd = '0; sd_wr = '0; sd_buff_din = '0;
    for (int i = 0; i < 524288; i++) mem[i] = 8'($urandom);
    s = "MV - CPCEMU Disk-File\r\nDisk-Info\r\n";
    for (int i = 0; i < s.len(); i++) mem[i] = s.getc(i);
    mem[32'h30] = 8'h28; mem[32'h31] = 8'h01; mem[32'h32] = 8'h00; mem[32'h33] = 8'h13;
    s = "Track-Info\r\n";
    for (int i = 0; i < s.len(); i++) mem[32'h100 + i] = s.getc(i);
    mem[32'h114] = 8'h02; mem[32'h115] = 8'h09;

    test_reset();
    test_header_read();
    test_lba_wrap();
    test_random_reads();
    test_held_request();
    test_write();
    test_reset_mid_read();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
